// File: rtl/transaccion_pkg.sv
// Shared definitions for the transaction-layer word counter.
// Holds default geometry, the reader FSM encoding and the saturation ceiling.
package transaccion_pkg;

    localparam int WC_NUM_LANES   = 4;
    localparam int WC_COUNT_WIDTH = 5;

    typedef enum logic [0:0] {
        WC_COUNT = 1'b0,
        WC_READ  = 1'b1
    } wc_state_t;

    localparam logic [WC_COUNT_WIDTH-1:0] WC_COUNT_MAX = {WC_COUNT_WIDTH{1'b1}};

endpackage

// File: rtl/word_counter_sat_counter.sv
// Single-lane saturating up-counter with a synchronous clear.
// A clear coinciding with an increment leaves the counter at 1.
module sat_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = WIDTH'(inc);
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/word_counter.sv
// Per-lane popped-word counter with a level-sensitive read port.
// Optional feature: define WORD_COUNTER_CLEAR_ON_READ_EN to clear a lane when it is read.
module word_counter
    import transaccion_pkg::*;
#(
    parameter int NUM_LANES   = WC_NUM_LANES,
    parameter int COUNT_WIDTH = WC_COUNT_WIDTH,
    parameter int IDX_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   idle,
    input  logic [NUM_LANES-1:0]   pop,
    input  logic [NUM_LANES-1:0]   empty,
    input  logic                   req,
    input  logic [IDX_W-1:0]       idx,
    output logic [COUNT_WIDTH-1:0] data,
    output logic                   valid
);

    wc_state_t              state_q, state_d;
    logic [COUNT_WIDTH-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   capture;
    logic [NUM_LANES-1:0]   inc;
    logic [NUM_LANES-1:0]   clr;
    logic [COUNT_WIDTH-1:0] cnt [NUM_LANES];

    // Reads are only honoured while the main FSM idles; requests are never queued.
    assign capture = req && idle;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign inc[gi] = pop[gi] && !empty[gi];

            sat_counter #(
                .WIDTH(COUNT_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc[gi]),
                .clr   (clr[gi]),
                .count (cnt[gi])
            );
        end
    endgenerate

`ifdef WORD_COUNTER_CLEAR_ON_READ_EN
    logic [IDX_W-1:0] last_idx_q;
    logic             clear_sel;

    // Clear on entry into READ, or whenever the reader moves to a different lane.
    assign clear_sel = capture && ((state_q == WC_COUNT) || (idx != last_idx_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx_q <= '0;
        end else if (capture) begin
            last_idx_q <= idx;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_clr
            assign clr[gi] = clear_sel && (idx == IDX_W'(gi));
        end
    endgenerate
`else
    assign clr = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            WC_COUNT: if (capture)  state_d = WC_READ;
            WC_READ:  if (!capture) state_d = WC_COUNT;
            default:                state_d = WC_COUNT;
        endcase
    end

    // Capture the pre-increment count; the lane counter updates on the same edge.
    always_comb begin
        data_d  = data_q;
        valid_d = capture;
        if (capture) begin
            data_d = cnt[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WC_COUNT;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_word_counter.sv
// Self-checking bench for word_counter: a reference model pushes expectations
// to a scoreboard queue as stimulus is driven; outputs are popped and compared after each edge.
module tb_word_counter;
    import transaccion_pkg::*;

    localparam int NL = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          idle = 1'b0;
    logic          req = 1'b0;
    logic [NL-1:0] pop = '0;
    logic [NL-1:0] empty = '1;
    logic [1:0]    idx = '0;
    logic [CW-1:0] data;
    logic          valid;

    always #5 clk = ~clk;

    word_counter #(
        .NUM_LANES   (NL),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .idle  (idle),
        .pop   (pop),
        .empty (empty),
        .req   (req),
        .idx   (idx),
        .data  (data),
        .valid (valid)
    );

    int checks = 0;
    int passed = 0;

    int m_cnt [NL];
    int m_data = 0;
    bit m_reading = 1'b0;
    int m_last = 0;

    typedef struct {
        string name;
        bit    v;
        int    d;
    } exp_t;
    exp_t sb [$];

    task automatic cycle(input string name, input bit rst, input bit r, input bit id,
                         input int ix, input logic [NL-1:0] p, input logic [NL-1:0] e);
        exp_t x;
        bit   cap;
        bit   clr_en;
        bit   inc;
        @(negedge clk);
        reset = rst;
        req   = r;
        idle  = id;
        idx   = 2'(ix);
        pop   = p;
        empty = e;
        if (rst) begin
            for (int l = 0; l < NL; l++) m_cnt[l] = 0;
            m_data    = 0;
            m_reading = 1'b0;
            m_last    = 0;
            x.v       = 1'b0;
        end else begin
            cap    = r && id;
            clr_en = 1'b0;
            if (cap) begin
                m_data = m_cnt[ix];
`ifdef WORD_COUNTER_CLEAR_ON_READ_EN
                clr_en = !m_reading || (ix != m_last);
`endif
                m_last = ix;
            end
            m_reading = cap;
            for (int l = 0; l < NL; l++) begin
                inc = p[l] && !e[l];
                if (clr_en && (l == ix)) m_cnt[l] = inc ? 1 : 0;
                else if (inc && (m_cnt[l] < int'(WC_COUNT_MAX))) m_cnt[l] = m_cnt[l] + 1;
            end
            x.v = cap;
        end
        x.d    = m_data;
        x.name = name;
        sb.push_back(x);

        @(posedge clk);
        #1;
        x = sb.pop_front();
        checks++;
        if (valid !== x.v) $display("FAIL %s valid: got %b expected %b", x.name, valid, x.v);
        else passed++;
        checks++;
        if (data !== CW'(x.d)) $display("FAIL %s data: got %0d expected %0d", x.name, data, x.d);
        else passed++;
    endtask

    task automatic test_reset();
        cycle("reset", 1, 0, 0, 0, '0, '1);
        cycle("reset", 1, 0, 0, 0, '0, '1);
        cycle("post_reset", 0, 0, 1, 0, '0, '1);
    endtask

    task automatic test_count_and_read();
        repeat (5) cycle("pop_l0", 0, 0, 1, 0, 4'b0001, 4'b0000);
        repeat (2) cycle("pop_l3", 0, 0, 1, 0, 4'b1000, 4'b0000);
        cycle("read_l0", 0, 1, 1, 0, '0, '0);
        cycle("read_l3", 0, 1, 1, 3, '0, '0);
        cycle("release", 0, 0, 1, 3, '0, '0);
    endtask

    task automatic test_empty_pop();
        repeat (4) cycle("pop_empty_l2", 0, 0, 1, 0, 4'b0100, 4'b0100);
        cycle("read_l2", 0, 1, 1, 2, '0, '0);
        cycle("release", 0, 0, 1, 2, '0, '0);
    endtask

    task automatic test_saturate();
        repeat (35) cycle("pop_l1", 0, 0, 1, 0, 4'b0010, 4'b0000);
        cycle("read_l1_sat", 0, 1, 1, 1, '0, '0);
        cycle("release", 0, 0, 1, 1, '0, '0);
    endtask

    task automatic test_idle_gate();
        repeat (3) cycle("req_not_idle", 0, 1, 0, 0, '0, '0);
        cycle("req_idle", 0, 1, 1, 0, '0, '0);
        cycle("idle_drop", 0, 1, 0, 0, '0, '0);
        cycle("release", 0, 0, 1, 0, '0, '0);
    endtask

    task automatic test_back_to_back();
        cycle("read_pop_same", 0, 1, 1, 2, 4'b0100, 4'b0000);
        cycle("reread_same", 0, 1, 1, 2, '0, '0);
        cycle("switch_l3", 0, 1, 1, 3, 4'b1000, 4'b0000);
        cycle("switch_l2", 0, 1, 1, 2, '0, '0);
        cycle("switch_l3b", 0, 1, 1, 3, '0, '0);
        cycle("release", 0, 0, 1, 3, '0, '0);
    endtask

    task automatic test_reset_mid_read();
        cycle("read_l1", 0, 1, 1, 1, '0, '0);
        cycle("reset_in_read", 1, 1, 1, 1, '0, '0);
        for (int l = 0; l < NL; l++) cycle("read_after_reset", 0, 1, 1, l, '0, '0);
        cycle("release", 0, 0, 1, 0, '0, '0);
    endtask

`ifdef WORD_COUNTER_CLEAR_ON_READ_EN
    task automatic test_clear_on_read();
        cycle("clr_reset", 1, 0, 0, 0, '0, '1);
        repeat (4) cycle("clr_pop_l0", 0, 0, 1, 0, 4'b0001, 4'b0000);
        cycle("clr_read_pop", 0, 1, 1, 0, 4'b0001, 4'b0000);
        cycle("clr_hold", 0, 1, 1, 0, '0, '0);
        cycle("clr_release", 0, 0, 1, 0, '0, '0);
        cycle("clr_reread", 0, 1, 1, 0, '0, '0);
        cycle("clr_release", 0, 0, 1, 0, '0, '0);
        cycle("clr_reread0", 0, 1, 1, 0, '0, '0);
        cycle("clr_release", 0, 0, 1, 0, '0, '0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle("random", ($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  NL'($urandom), NL'($urandom));
        end
    endtask

    initial begin
        for (int l = 0; l < NL; l++) m_cnt[l] = 0;
        test_reset();
        test_count_and_read();
        test_empty_pop();
        test_saturate();
        test_idle_gate();
        test_back_to_back();
        test_reset_mid_read();
`ifdef WORD_COUNTER_CLEAR_ON_READ_EN
        test_clear_on_read();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
